// File: rtl/sim_bus_monitor.sv
// Passive core-to-memory bus monitor: halt-address detect, cycle watchdog and
// an I/O-region trace FIFO drained through a valid/ready port.
module sim_bus_monitor #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = 32'h00000FFC,
    parameter int                IO_BIT     = 11,
    parameter int                FIFO_DEPTH = 8,
    parameter int                TIMEOUT    = 2000,
    parameter int                CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             memory_address,
    input  logic [DATA_W-1:0]             memory_data_out,
    input  logic [DATA_W-1:0]             memory_data_in,
    input  logic                          memory_write_enable,
    output logic                          halt,
    output logic [1:0]                    halt_cause,
    output logic [CNT_W-1:0]              cycle_count,
    output logic [CNT_W-1:0]              io_wr_count,
    output logic [CNT_W-1:0]              io_rd_count,
    output logic [CNT_W-1:0]              drop_count,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic                          trace_we,
    output logic [ADDR_W-1:0]             trace_addr,
    output logic [DATA_W-1:0]             trace_data,
    output logic [$clog2(FIFO_DEPTH):0]   trace_level,
    output logic                          trace_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    FULL    = LW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } trace_t;

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state;
    trace_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [LW-1:0]   level;
    trace_t          entry, head;
    logic            in_run, hit_halt, hit_io, hit_to;
    logic            push_req, push_ok, pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        in_run     = (state == RUN);
        hit_halt   = (memory_address == HALT_ADDR);
        hit_io     = memory_address[IO_BIT] && !hit_halt;
        hit_to     = (TIMEOUT != 0) && (cycle_count == TO_LAST);
        push_req   = in_run && hit_io;
        pop        = (level != '0) && trace_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push_ok    = push_req && ((level != FULL) || pop);
        entry.we   = memory_write_enable;
        entry.addr = memory_address;
        entry.data = memory_write_enable ? memory_data_out : memory_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            halt_cause     <= 2'd0;
            cycle_count    <= '0;
            io_wr_count    <= '0;
            io_rd_count    <= '0;
            drop_count     <= '0;
            trace_overflow <= 1'b0;
            wptr           <= '0;
            rptr           <= '0;
            level          <= '0;
        end else begin
            if (in_run) begin
                cycle_count <= sat_inc(cycle_count);
                if (hit_halt) begin
                    state      <= HALTED;
                    halt_cause <= 2'd1;
                end else if (hit_to) begin
                    state      <= HALTED;
                    halt_cause <= 2'd2;
                end
            end
            if (push_ok) begin
                wptr <= wptr + AW'(1);
                if (memory_write_enable) io_wr_count <= sat_inc(io_wr_count);
                else                     io_rd_count <= sat_inc(io_rd_count);
            end
            if (push_req && !push_ok) begin
                drop_count     <= sat_inc(drop_count);
                trace_overflow <= 1'b1;
            end
            if (pop) rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wptr] <= entry;
    end

    always_comb begin
        head        = mem[rptr];
        trace_valid = (level != '0);
        trace_we    = 1'b0;
        trace_addr  = '0;
        trace_data  = '0;
        if (trace_valid) begin
            trace_we   = head.we;
            trace_addr = head.addr;
            trace_data = head.data;
        end
    end

    assign halt        = (state == HALTED);
    assign trace_level = level;

endmodule

// File: tb/tb_sim_bus_monitor.sv
// Directed bench for sim_bus_monitor (FIFO_DEPTH 8, watchdog TIMEOUT 50).
module tb_sim_bus_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memory_address, memory_data_out, memory_data_in;
    logic        memory_write_enable;
    logic        halt;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, io_wr_count, io_rd_count, drop_count;
    logic        trace_valid, trace_ready, trace_we;
    logic [31:0] trace_addr, trace_data;
    logic [3:0]  trace_level;
    logic        trace_overflow;

    int n_chk  = 0;
    int n_pass = 0;

    sim_bus_monitor #(.FIFO_DEPTH(8), .TIMEOUT(50)) u_dut (
        .clk(clk), .reset(reset),
        .memory_address(memory_address), .memory_data_out(memory_data_out),
        .memory_data_in(memory_data_in), .memory_write_enable(memory_write_enable),
        .halt(halt), .halt_cause(halt_cause), .cycle_count(cycle_count),
        .io_wr_count(io_wr_count), .io_rd_count(io_rd_count), .drop_count(drop_count),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_we(trace_we),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_level(trace_level),
        .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memory_address      = 32'h100;
        memory_write_enable = 1'b0;
        memory_data_out     = 32'h0;
        memory_data_in      = 32'h0;
    endtask

    task automatic bus(input logic [31:0] a, input logic we, input logic [31:0] dout,
                       input logic [31:0] din);
        memory_address      = a;
        memory_write_enable = we;
        memory_data_out     = dout;
        memory_data_in      = din;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        trace_ready = 1'b0;
        do_reset();
        chk("rst_halt", halt, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_valid", trace_valid, 0);
        chk("rst_level", trace_level, 0);

        // idle run
        repeat (20) step();
        chk("idle_cycles", cycle_count, 20);
        chk("idle_valid", trace_valid, 0);
        chk("idle_halt", halt, 0);

        // single I/O write
        do_reset();
        bus(32'h800, 1'b1, 32'hAB, 32'h5555);
        step();
        idle();
        chk("wr_valid", trace_valid, 1);
        chk("wr_we", trace_we, 1);
        chk("wr_addr", trace_addr, 32'h800);
        chk("wr_data", trace_data, 32'hAB);
        chk("wr_cnt", io_wr_count, 1);
        chk("wr_rdcnt", io_rd_count, 0);
        chk("wr_level", trace_level, 1);

        // I/O read with consumer always ready
        do_reset();
        trace_ready = 1'b1;
        bus(32'h812, 1'b0, 32'hDEAD, 32'h1234);
        step();
        idle();
        chk("rd_valid", trace_valid, 1);
        chk("rd_we", trace_we, 0);
        chk("rd_addr", trace_addr, 32'h812);
        chk("rd_data", trace_data, 32'h1234);
        chk("rd_level", trace_level, 1);
        step();
        chk("rd_popped", trace_valid, 0);
        chk("rd_level0", trace_level, 0);
        chk("rd_empty_data", trace_data, 0);
        chk("rd_cnt", io_rd_count, 1);

        // overflow: 10 writes into an 8-deep FIFO
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus(32'h800 + 32'(4 * i), 1'b1, 32'h100 + 32'(i), 32'h0);
            step();
        end
        idle();
        chk("ov_level", trace_level, 8);
        chk("ov_drop", drop_count, 2);
        chk("ov_flag", trace_overflow, 1);
        chk("ov_wrcnt", io_wr_count, 8);
        chk("ov_head_addr", trace_addr, 32'h800);
        chk("ov_head_data", trace_data, 32'h100);
        // push while full and popping is accepted
        trace_ready = 1'b1;
        bus(32'h900, 1'b1, 32'h55, 32'h0);
        step();
        idle();
        chk("pp_level", trace_level, 8);
        chk("pp_drop", drop_count, 2);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("drain%0d_addr", i), trace_addr, 32'h800 + 32'(4 * i));
            chk($sformatf("drain%0d_data", i), trace_data, 32'h100 + 32'(i));
            step();
        end
        chk("drain_last_addr", trace_addr, 32'h900);
        chk("drain_last_data", trace_data, 32'h55);
        step();
        chk("drain_empty", trace_valid, 0);
        trace_ready = 1'b0;

        // halt address after 30 idle cycles
        do_reset();
        repeat (30) step();
        chk("ha_pre_halt", halt, 0);
        bus(32'hFFC, 1'b1, 32'h77, 32'h0);
        step();
        idle();
        chk("ha_halt", halt, 1);
        chk("ha_cause", halt_cause, 1);
        chk("ha_cycles", cycle_count, 31);
        chk("ha_no_push", trace_valid, 0);
        bus(32'h800, 1'b1, 32'h99, 32'h0);
        repeat (3) step();
        idle();
        chk("ha_frozen", cycle_count, 31);
        chk("ha_ignored", trace_valid, 0);
        chk("ha_wrcnt", io_wr_count, 0);

        // halt address wins over the watchdog in the same cycle
        do_reset();
        repeat (49) step();
        bus(32'hFFC, 1'b0, 32'h0, 32'h0);
        step();
        idle();
        chk("prio_cause", halt_cause, 1);
        chk("prio_halt", halt, 1);

        // watchdog, with the FIFO overflowed beforehand
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus(32'hA00 + 32'(i), 1'b1, 32'(i), 32'h0);
            step();
        end
        idle();
        repeat (39) step();
        chk("to_pre_halt", halt, 0);
        chk("to_pre_cycles", cycle_count, 49);
        bus(32'h804, 1'b1, 32'h77, 32'h0);
        step();
        idle();
        chk("to_halt", halt, 1);
        chk("to_cause", halt_cause, 2);
        chk("to_cycles", cycle_count, 50);
        chk("to_captured_drop", drop_count, 3);
        step();
        chk("to_frozen", cycle_count, 50);
        do_reset();
        chk("to_rst_halt", halt, 0);
        chk("to_rst_cause", halt_cause, 0);
        chk("to_rst_cycles", cycle_count, 0);
        chk("to_rst_wrcnt", io_wr_count, 0);
        chk("to_rst_drop", drop_count, 0);
        chk("to_rst_level", trace_level, 0);
        chk("to_rst_ovf", trace_overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sim_bus_monitor.md
Name: sim_bus_monitor

Overview:
- Synthesizable bus monitor that sits on the core-to-memory bus and observes it passively.
- Detects the halt address and enforces a cycle-count watchdog.
- Captures every I/O-region access (address bit IO_BIT set) into a trace FIFO that the bench or a debug port drains.
- Replaces the ad-hoc halt, timeout and logging logic in benches with one parametrised, reusable block.

Parameters:
- ADDR_W, 32, width of memory_address.
- DATA_W, 32, width of the data buses.
- HALT_ADDR, 32'h00000FFC, address that terminates the run.
- IO_BIT, 11, address bit that marks the I/O region.
- FIFO_DEPTH, 8, trace entries; power of two, at least 2.
- TIMEOUT, 2000, cycles in RUN before a watchdog halt; 0 disables the watchdog.
- CNT_W, 32, width of all counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memory_address  in  ADDR_W  bus address.
- memory_data_out  in  DATA_W  core write data.
- memory_data_in  in  DATA_W  memory read data.
- memory_write_enable  in  1  1 = write, 0 = read.
- halt  out  1  sticky; run finished.
- halt_cause  out  2  0 = none, 1 = halt address, 2 = timeout.
- cycle_count  out  CNT_W  cycles spent in RUN.
- io_wr_count  out  CNT_W  I/O writes captured.
- io_rd_count  out  CNT_W  I/O reads captured.
- drop_count  out  CNT_W  I/O accesses lost because the FIFO was full.
- trace_valid  out  1  FIFO not empty.
- trace_ready  in  1  consumer pops the head entry when trace_valid is also 1.
- trace_we  out  1  head entry write flag.
- trace_addr  out  ADDR_W  head entry address.
- trace_data  out  DATA_W  head entry data: write data for writes, read data for reads.
- trace_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- trace_overflow  out  1  sticky; at least one entry was dropped.

Behaviour:
- Reset: reset is sampled only on the rising edge of clk.
  - On reset, all outputs are 0, the FIFO is emptied and the FSM enters RUN.
  - Reset overrides every other event in the same cycle, including a pending halt or a push.
- FSM states: RUN and HALTED. HALTED is left only through reset.
- RUN, evaluated at each rising edge on the sampled bus:
  - cycle_count increments by 1.
  - If memory_address == HALT_ADDR: go to HALTED, halt_cause = 1. No trace push, even if bit IO_BIT is set.
  - Else, if TIMEOUT != 0 and cycle_count == TIMEOUT-1: go to HALTED, halt_cause = 2. The access in that cycle is still captured.
  - The halt address takes priority over the timeout in the same cycle.
- Capture: an access is captured when memory_address[IO_BIT] == 1 and the address is not HALT_ADDR.
  - Every such cycle is captured, including back-to-back cycles at the same address.
  - The pushed entry is {memory_write_enable, memory_address, write ? memory_data_out : memory_data_in}.
  - io_wr_count or io_rd_count increments on each accepted push.
- halt output: rises in the cycle after the edge that sampled the halt condition, so halt is 1 whenever the FSM is in HALTED.
- HALTED:
  - No pushes; cycle_count and the I/O counters are frozen.
  - The FIFO still drains through trace_valid/trace_ready.
  - Bus activity is ignored.
- FIFO structure: circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
- FIFO latency: an entry captured at edge N is visible at the head by N+1 when the FIFO was empty. This is registered output, no combinational path from the bus to the trace outputs.
- Full FIFO:
  - A push is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped, drop_count increments and trace_overflow sets and stays set.
- Simultaneous push and pop: level is unchanged and the entry order is preserved.
- Empty FIFO: trace_valid = 0 and trace_we/trace_addr/trace_data read 0. trace_ready is ignored.
- Counter width: all counters saturate at all-ones and never wrap.

Test Plan:
- Reset, then idle bus at 0x100 for 20 cycles:
  - cycle_count = 20, trace_valid = 0, halt = 0.
- Write of 0x000000AB to 0x800:
  - trace_valid rises 1 cycle later with trace_we = 1, addr = 0x800, data = 0xAB.
  - io_wr_count = 1.
- Read of 0x812 returning 0x1234 with trace_ready held at 1:
  - entry {0, 0x812, 0x1234} is popped one cycle after it appears, and level returns to 0.
- 10 consecutive I/O writes with trace_ready = 0 and FIFO_DEPTH = 8:
  - trace_level = 8, drop_count = 2, trace_overflow = 1.
  - Draining then yields the first 8 entries in order.
- Address 0xFFC presented at cycle 30:
  - halt = 1 and halt_cause = 1 from cycle 31; cycle_count freezes at 31.
  - A later write to 0x800 is not captured.
- TIMEOUT = 50 with the bus idle:
  - halt_cause = 2 and halt = 1 after 50 RUN cycles.
  - Asserting reset for 1 cycle clears halt, the counters, the FIFO and trace_overflow.
